// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a shared combinational ALU.
// Each accepted operation takes IDLE -> ISSUE -> RESP; the response is held until consumed.
module alu_issue_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [6:0]       req0_func7,
   input  logic [2:0]       req0_func3,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [6:0]       req1_func7,
   input  logic [2:0]       req1_func3,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             alu_en,
   output logic [6:0]       alu_func7,
   output logic [2:0]       alu_func3,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [2:0]       alu_operation,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           state_r;
   logic             last_grant_r;
   logic             id_r;
   logic [6:0]       func7_r;
   logic [2:0]       func3_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             alu_en_r;
   logic             rsp_valid_r;
   logic             rsp_id_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic             rsp_err_r;

   logic             grant_s;
   logic             ready0_s;
   logic             ready1_s;
   logic             accept_s;
   logic [6:0]       sel_func7_s;
   logic [2:0]       sel_func3_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;

   // Op codes 5 (unsupported) and 7 (disabled) mark the response as an error.
   function automatic logic op_is_error(input logic [2:0] op);
      case (op)
         3'd5, 3'd7: return 1'b1;
         default:    return 1'b0;
      endcase
   endfunction

   // Round-robin grant: a tie goes to the requester that did not win last time.
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_grant_r;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Ready only in IDLE and only toward the granted, currently valid requester.
   always_comb begin
      ready0_s = (state_r == IDLE) && req0_valid && !grant_s;
      ready1_s = (state_r == IDLE) && req1_valid &&  grant_s;
      accept_s = ready0_s || ready1_s;
   end

   // Select the granted requester's fields for capture at the handshake.
   always_comb begin
      sel_func7_s = req0_func7;
      sel_func3_s = req0_func3;
      sel_a_s     = req0_a;
      sel_b_s     = req0_b;
      if (grant_s) begin
         sel_func7_s = req1_func7;
         sel_func3_s = req1_func3;
         sel_a_s     = req1_a;
         sel_b_s     = req1_b;
      end else begin
         sel_func7_s = req0_func7;
         sel_func3_s = req0_func3;
         sel_a_s     = req0_a;
         sel_b_s     = req0_b;
      end
   end

   // Main FSM: capture request, drive ALU for one cycle, hold response until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b1;
         id_r         <= 1'b0;
         func7_r      <= 7'd0;
         func3_r      <= 3'd0;
         a_r          <= '0;
         b_r          <= '0;
         alu_en_r     <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_id_r     <= 1'b0;
         rsp_data_r   <= '0;
         rsp_err_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  func7_r      <= sel_func7_s;
                  func3_r      <= sel_func3_s;
                  a_r          <= sel_a_s;
                  b_r          <= sel_b_s;
                  id_r         <= grant_s;
                  last_grant_r <= grant_s;
                  alu_en_r     <= 1'b1;
                  state_r      <= ISSUE;
               end else begin
                  alu_en_r     <= 1'b0;
                  state_r      <= IDLE;
               end
            end
            ISSUE: begin
               alu_en_r    <= 1'b0;
               rsp_data_r  <= alu_result;
               rsp_err_r   <= op_is_error(alu_operation);
               rsp_id_r    <= id_r;
               rsp_valid_r <= 1'b1;
               state_r     <= RESP;
            end
            RESP: begin
               alu_en_r <= 1'b0;
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end
            end
            default: begin
               alu_en_r    <= 1'b0;
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign req0_ready = ready0_s;
   assign req1_ready = ready1_s;
   assign alu_en     = alu_en_r;
   assign alu_func7  = func7_r;
   assign alu_func3  = func3_r;
   assign alu_a      = a_r;
   assign alu_b      = b_r;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_data   = rsp_data_r;
   assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: expected responses are queued at accept time
// and a negedge monitor pops and compares each consumed response.
module tb_alu_issue_arbiter;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [6:0]   req0_func7, req1_func7;
   logic [2:0]   req0_func3, req1_func3;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         alu_en;
   logic [6:0]   alu_func7;
   logic [2:0]   alu_func3;
   logic [W-1:0] alu_a, alu_b;
   logic [2:0]   alu_operation;
   logic [W-1:0] alu_result;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [W-1:0] rsp_data;

   typedef struct packed {
      logic         id;
      logic [W-1:0] data;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu_issue_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_func7(req0_func7), .req0_func3(req0_func3), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_func7(req1_func7), .req1_func3(req1_func3), .req1_a(req1_a), .req1_b(req1_b),
      .alu_en(alu_en), .alu_func7(alu_func7), .alu_func3(alu_func3),
      .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for ALU control plus ALU.
   always_comb begin
      alu_operation = 3'd7;
      alu_result    = '0;
      if (!alu_en) begin
         alu_operation = 3'd7;
      end else if (alu_func7 == 7'h00 && alu_func3 == 3'd0) begin
         alu_operation = 3'd0; alu_result = alu_a + alu_b;
      end else if (alu_func7 == 7'h20 && alu_func3 == 3'd0) begin
         alu_operation = 3'd1; alu_result = alu_a - alu_b;
      end else if (alu_func7 == 7'h00 && alu_func3 == 3'd7) begin
         alu_operation = 3'd2; alu_result = alu_a & alu_b;
      end else if (alu_func7 == 7'h00 && alu_func3 == 3'd6) begin
         alu_operation = 3'd3; alu_result = alu_a | alu_b;
      end else if (alu_func7 == 7'h00 && alu_func3 == 3'd4) begin
         alu_operation = 3'd4; alu_result = alu_a ^ alu_b;
      end else begin
         alu_operation = 3'd5; alu_result = 32'hDEAD_BEEF;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      req0_valid = v; req0_func7 = f7; req0_func3 = f3; req0_a = a; req0_b = b;
   endtask

   task automatic set1(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      req1_valid = v; req1_func7 = f7; req1_func3 = f3; req1_a = a; req1_b = b;
   endtask

   task automatic push(input logic id, input logic [W-1:0] data, input logic err);
      exp_t e;
      e.id = id; e.data = data; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: a response is consumed on the next rising edge when valid and ready.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {63'd0, rsp_id}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
            chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
            chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      rsp_ready = 1'b0;
      set0(1'b0, 7'd0, 3'd0, 32'd0, 32'd0);
      set1(1'b0, 7'd0, 3'd0, 32'd0, 32'd0);

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_alu_en", {63'd0, alu_en}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
      chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
      chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
      chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
      chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
      step();
      rst_n = 1'b1;

      // Single op: 5 + 3 = 8 on requester 0, latency t / t+1 / t+2
      rsp_ready = 1'b1;
      set0(1'b1, 7'h00, 3'd0, 32'd5, 32'd3);
      @(negedge clk);
      chk("single_ready0", {63'd0, req0_ready}, 64'd1);
      chk("single_ready1", {63'd0, req1_ready}, 64'd0);
      push(1'b0, 32'd8, 1'b0);
      step();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("single_alu_en_t1", {63'd0, alu_en}, 64'd1);
      chk("single_alu_a", {32'd0, alu_a}, 64'd5);
      chk("single_alu_b", {32'd0, alu_b}, 64'd3);
      chk("single_rsp_valid_t1", {63'd0, rsp_valid}, 64'd0);
      step();
      @(negedge clk);
      chk("single_rsp_valid_t2", {63'd0, rsp_valid}, 64'd1);
      chk("single_alu_en_t2", {63'd0, alu_en}, 64'd0);
      chk("single_alu_a_hold", {32'd0, alu_a}, 64'd5);
      step();
      drain("single_drain");

      // Tie after reset: grants 0,1,0,1 at cycles 0,3,6,9
      do_reset();
      rsp_ready = 1'b1;
      set0(1'b1, 7'h00, 3'd0, 32'd10, 32'd4);
      set1(1'b1, 7'h20, 3'd0, 32'd20, 32'd7);
      push(1'b0, 32'd14, 1'b0);
      push(1'b1, 32'd13, 1'b0);
      push(1'b0, 32'd14, 1'b0);
      push(1'b1, 32'd13, 1'b0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("tie_ready0_c%0d", i), {63'd0, req0_ready},
             {63'd0, (i % 3 == 0) && ((i / 3) % 2 == 0)});
         chk($sformatf("tie_ready1_c%0d", i), {63'd0, req1_ready},
             {63'd0, (i % 3 == 0) && ((i / 3) % 2 == 1)});
         step();
         if (i == 9) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end
      end
      drain("tie_drain");

      // Backpressure with a withdrawn req0 pulse during RESP
      rsp_ready = 1'b0;
      set1(1'b1, 7'h00, 3'd7, 32'h0000_F0F0, 32'h0000_FF00);
      @(negedge clk);
      chk("bp_ready1", {63'd0, req1_ready}, 64'd1);
      push(1'b1, 32'h0000_F000, 1'b0);
      step();
      req1_valid = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         if (k == 1) set0(1'b1, 7'h00, 3'd0, 32'd99, 32'd1);
         @(negedge clk);
         chk($sformatf("bp_valid_c%0d", k), {63'd0, rsp_valid}, 64'd1);
         chk($sformatf("bp_data_c%0d", k), {32'd0, rsp_data}, 64'h0000_F000);
         chk($sformatf("bp_ready_c%0d", k), {62'd0, req1_ready, req0_ready}, 64'd0);
         step();
         if (k == 1) req0_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      step();
      set0(1'b1, 7'h00, 3'd6, 32'h0000_000F, 32'h0000_00F0);
      @(negedge clk);
      chk("bp_idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("bp_idle_ready0", {63'd0, req0_ready}, 64'd1);
      push(1'b0, 32'h0000_00FF, 1'b0);
      step();
      req0_valid = 1'b0;
      drain("bp_drain");

      // Unsupported op on requester 1
      set1(1'b1, 7'h01, 3'd0, 32'd1, 32'd2);
      @(negedge clk);
      chk("unsup_ready1", {63'd0, req1_ready}, 64'd1);
      push(1'b1, 32'hDEAD_BEEF, 1'b1);
      step();
      req1_valid = 1'b0;
      drain("unsup_drain");

      // Reset during ISSUE aborts the op; req1-only request accepted afterwards
      set0(1'b1, 7'h00, 3'd0, 32'd7, 32'd7);
      @(negedge clk);
      chk("rmid_ready0", {63'd0, req0_ready}, 64'd1);
      step();
      req0_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmid_alu_en", {63'd0, alu_en}, 64'd0);
      chk("rmid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      set1(1'b1, 7'h00, 3'd4, 32'h0000_00FF, 32'h0000_000F);
      @(negedge clk);
      chk("rmid_ready1", {63'd0, req1_ready}, 64'd1);
      chk("rmid_ready0_low", {63'd0, req0_ready}, 64'd0);
      push(1'b1, 32'h0000_00F0, 1'b0);
      step();
      req1_valid = 1'b0;
      drain("rmid_drain");

      // Nothing further may appear
      repeat (6) step();
      chk("no_spurious", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
